// File: rtl/timer_dev_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_dev_pkg
// Description : Register offsets, CTRL bit positions, MODE encodings and FSM
//               state encodings shared by the timer and its bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_dev_pkg;

    localparam int         c_DATA_W          = 32;

    localparam logic [1:0] c_ADDR_CTRL       = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET     = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT      = 2'd2;

    localparam int         c_CTRL_EN_BIT     = 0;
    localparam int         c_CTRL_MODE_LSB   = 1;
    localparam int         c_CTRL_MODE_MSB   = 2;
    localparam int         c_CTRL_IM_BIT     = 3;

    localparam logic [1:0] c_MODE_ONESHOT    = 2'b00;
    localparam logic [1:0] c_MODE_AUTORELOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CNT  = 2'd1,
        ST_INT  = 2'd2
    } timer_state_e;

endpackage
`default_nettype wire

// File: rtl/timer_dev_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_dev_if
// Description : CPU register bus between the bridge (master) and the timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_dev_if;
    import timer_dev_pkg::*;

    logic [1:0]          addr;
    logic                we;
    logic [c_DATA_W-1:0] din;
    logic [c_DATA_W-1:0] dout;

    modport master (output addr, output we, output din, input  dout);
    modport slave  (input  addr, input  we, input  din, output dout);

endinterface
`default_nettype wire

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : timer_dev
// Description : 32-bit down-counting timer with CTRL/PRESET/COUNT registers,
//               one-shot and auto-reload modes and a maskable interrupt.
//               Auto-reload is built only when TIMER_AUTORELOAD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_dev
    import timer_dev_pkg::*;
(
    input  wire         clk,
    input  wire         rst,
    timer_dev_if.slave  bus,
    output logic        irq
);

    logic [3:0]          r_ctrl;
    logic [c_DATA_W-1:0] r_preset;
    logic [c_DATA_W-1:0] r_count;
    logic                r_int_flag;
    logic                r_irq;
    timer_state_e        r_state;

    timer_state_e        w_state_nxt;
    logic [c_DATA_W-1:0] w_count_nxt;
    logic                w_flag_set;
    logic                w_flag_clr_fsm;
    logic                w_en_clr;
    logic [3:0]          w_ctrl_nxt;
    logic                w_flag_nxt;
    logic                w_wr_ctrl;
    logic                w_wr_preset;
    logic                w_en;
    logic [1:0]          w_mode;

    assign w_wr_ctrl   = bus.we && (bus.addr == c_ADDR_CTRL);
    assign w_wr_preset = bus.we && (bus.addr == c_ADDR_PRESET);
    assign w_en        = r_ctrl[c_CTRL_EN_BIT];
    assign w_mode      = r_ctrl[c_CTRL_MODE_MSB:c_CTRL_MODE_LSB];

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_flag_set     = 1'b0;
        w_flag_clr_fsm = 1'b0;
        w_en_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en) begin
                    w_count_nxt = r_preset;
                    w_state_nxt = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!w_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count != '0) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    w_flag_set  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
`ifdef TIMER_AUTORELOAD_EN
                if (w_mode == c_MODE_AUTORELOAD) begin
                    w_count_nxt    = r_preset;
                    w_flag_clr_fsm = 1'b1;
                    w_state_nxt    = ST_CNT;
                end else begin
                    w_en_clr    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`else
                w_en_clr    = 1'b1;
                w_state_nxt = ST_IDLE;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A CPU write to CTRL overrides the FSM's EN clear on the same edge.
    assign w_ctrl_nxt = w_wr_ctrl ? bus.din[3:0] :
                        w_en_clr  ? {r_ctrl[3:1], 1'b0} : r_ctrl;

    // A fresh expiry is never lost to a coincident CPU write.
    assign w_flag_nxt = w_flag_set ? 1'b1 :
                        (w_flag_clr_fsm || w_wr_ctrl || w_wr_preset) ? 1'b0 : r_int_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_int_flag <= 1'b0;
            r_irq      <= 1'b0;
            r_state    <= ST_IDLE;
        end else begin
            r_ctrl     <= w_ctrl_nxt;
            r_count    <= w_count_nxt;
            r_int_flag <= w_flag_nxt;
            r_irq      <= w_ctrl_nxt[c_CTRL_IM_BIT] & w_flag_nxt;
            r_state    <= w_state_nxt;
            if (w_wr_preset) begin
                r_preset <= bus.din;
            end
        end
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            c_ADDR_CTRL:   bus.dout = {28'd0, r_ctrl};
            c_ADDR_PRESET: bus.dout = r_preset;
            c_ADDR_COUNT:  bus.dout = r_count;
            default:       bus.dout = '0;
        endcase
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_dev
// Description : Scoreboard bench for timer_dev; stimulus queues expected
//               register reads / irq levels, a negedge monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic        irq;
    logic [1:0]  stim_addr;
    logic        stim_we;
    logic [31:0] stim_din;
    logic [1:0]  mon_addr;
    logic        mon_active;

    int n_checks;
    int n_fail;

    typedef struct {
        bit          is_irq;
        logic [1:0]  addr;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [31:0] got;

    timer_dev_if bus();

    assign bus.addr = mon_active ? mon_addr : stim_addr;
    assign bus.we   = stim_we;
    assign bus.din  = stim_din;

    timer_dev dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        mon_active = 1'b0;
        mon_addr   = 2'd0;
    end

    // Monitor: drains every expectation queued during the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.is_irq) begin
                got = {31'd0, irq};
            end else begin
                mon_addr   = cur.addr;
                mon_active = 1'b1;
                #1;
                got = bus.dout;
            end
            n_checks++;
            if (got !== cur.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", cur.name, got, cur.exp);
            end
        end
        mon_active = 1'b0;
    end

    task automatic exp_reg(input logic [1:0] a, input logic [31:0] v, input string nm);
        exp_t e;
        e.is_irq = 1'b0;
        e.addr   = a;
        e.exp    = v;
        e.name   = nm;
        exp_q.push_back(e);
    endtask

    task automatic exp_irq(input logic v, input string nm);
        exp_t e;
        e.is_irq = 1'b1;
        e.addr   = 2'd0;
        e.exp    = {31'd0, v};
        e.name   = nm;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        stim_addr = a;
        stim_din  = d;
        stim_we   = 1'b1;
        @(posedge clk);
        #1;
        stim_we   = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        stim_we   = 1'b0;
        stim_addr = 2'd0;
        stim_din  = 32'd0;
        #2 rst = 1'b0;
        tick();
        exp_reg(2'd0, 32'd0, "rst_ctrl");
        exp_reg(2'd1, 32'd0, "rst_preset");
        exp_reg(2'd2, 32'd0, "rst_count");
        exp_irq(1'b0, "rst_irq");
        tick();
        rst = 1'b1;
        tick();

        // One-shot, IM set: irq on the 7th edge after the CTRL write, sticky.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_irq(k >= 7, $sformatf("os_irq_%0d", k));
            if (k == 1) exp_reg(2'd2, 32'd5, "os_count_load");
            if (k == 6) exp_reg(2'd2, 32'd0, "os_count_zero");
            if (k == 7) exp_reg(2'd0, 32'h9, "os_ctrl_at_int");
            if (k == 8) exp_reg(2'd0, 32'h8, "os_en_cleared");
        end
        wr(2'd0, 32'h0);
        exp_irq(1'b0, "os_irq_cleared");
        tick();

        // Auto-reload request: periodic pulses only when the feature is built.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 21; k++) begin
            tick();
`ifdef TIMER_AUTORELOAD_EN
            exp_irq((k >= 5) && (((k - 5) % 5) == 0), $sformatf("ar_irq_%0d", k));
`else
            exp_irq(k >= 5, $sformatf("ar_irq_%0d", k));
`endif
            if (k == 1) exp_reg(2'd2, 32'd3, "ar_count_load");
        end
`ifdef TIMER_AUTORELOAD_EN
        exp_reg(2'd0, 32'hB, "ar_ctrl");
`else
        exp_reg(2'd0, 32'hA, "ar_ctrl");
`endif
        wr(2'd0, 32'h0);
        exp_irq(1'b0, "ar_irq_stop");
        tick();
        tick();

        // Masked expiry, then IM write with EN=0 must not raise irq.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_irq(1'b0, $sformatf("mask_irq_%0d", k));
            if (k == 3) exp_reg(2'd2, 32'd0, "mask_count_zero");
        end
        exp_reg(2'd0, 32'h0, "mask_ctrl_en_clr");
        wr(2'd0, 32'h8);
        exp_irq(1'b0, "mask_im_irq");
        exp_reg(2'd0, 32'h8, "mask_im_ctrl");
        tick();
        exp_irq(1'b0, "mask_im_irq2");
        wr(2'd0, 32'h0);

        // Pause at COUNT=10, resume reloads PRESET, PRESET write mid-count.
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1)  exp_reg(2'd2, 32'd20, "pz_count_load");
            if (k == 10) exp_reg(2'd2, 32'd11, "pz_count_11");
        end
        wr(2'd0, 32'h0);
        exp_reg(2'd2, 32'd10, "pz_count_10");
        tick();
        exp_reg(2'd2, 32'd10, "pz_hold_a");
        tick();
        exp_reg(2'd2, 32'd10, "pz_hold_b");
        wr(2'd1, 32'd7);
        exp_reg(2'd2, 32'd10, "pz_preset_idle");
        wr(2'd0, 32'h1);
        exp_reg(2'd2, 32'd10, "pz_en_edge");
        tick();
        exp_reg(2'd2, 32'd7, "pz_reload");
        tick();
        exp_reg(2'd2, 32'd6, "pz_dec");
        wr(2'd1, 32'd50);
        exp_reg(2'd2, 32'd5, "pz_preset_in_cnt");
        exp_reg(2'd1, 32'd50, "pz_preset_rd");
        tick();
        exp_reg(2'd2, 32'd4, "pz_dec2");
        wr(2'd0, 32'h0);
        tick();

        // Writes to COUNT and reserved offsets are ignored.
        wr(2'd1, 32'hA5A5_0F0F);
        wr(2'd2, 32'hFFFF_FFFF);
        wr(2'd3, 32'h0000_000F);
        exp_reg(2'd2, 32'd3, "ro_count");
        exp_reg(2'd3, 32'd0, "ro_rsvd");
        exp_reg(2'd0, 32'h0, "ro_ctrl");
        exp_reg(2'd1, 32'hA5A5_0F0F, "ro_preset");
        tick();

        // PRESET=0 expiry and CPU CTRL write colliding with the INT edge.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        exp_irq(1'b0, "p0_irq_e1");
        tick();
        exp_irq(1'b1, "p0_irq_e2");
        wr(2'd0, 32'hD);
        exp_reg(2'd0, 32'hD, "col_ctrl");
        exp_irq(1'b0, "col_irq");
        tick();
        exp_irq(1'b0, "col_irq_e4");
        tick();
        exp_irq(1'b1, "col_irq_e5");
        tick();
        exp_irq(1'b1, "col_irq_e6");
        exp_reg(2'd0, 32'hC, "col_en_clr");
        wr(2'd0, 32'h0);
        exp_irq(1'b0, "col_irq_off");
        tick();

        // Reset mid-count aborts; nothing restarts until EN is written.
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        repeat (5) tick();
        rst = 1'b0;
        exp_reg(2'd0, 32'h0, "mr_ctrl");
        exp_reg(2'd1, 32'h0, "mr_preset");
        exp_reg(2'd2, 32'h0, "mr_count");
        exp_irq(1'b0, "mr_irq");
        tick();
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 110; k++) begin
            tick();
            if ((k % 20) == 0) exp_irq(1'b0, $sformatf("mr_idle_irq_%0d", k));
        end
        exp_reg(2'd2, 32'h0, "mr_idle_count");
        wr(2'd0, 32'h9);
        tick();
        exp_irq(1'b0, "mr_resume_e1");
        tick();
        exp_irq(1'b1, "mr_resume_e2");
        wr(2'd0, 32'h0);
        tick();
        tick();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
